led_sel_ctrl: RTL and testbench
===============================

Name: led_sel_ctrl

Overview:
- Upstream control stage for the LED driver: turns two raw push-buttons into the 3-bit `sel` bus the driver consumes.
- Each button passes through a 2-FF synchronizer and a counter-based debouncer; a two-state mode FSM then produces `sel`.
- MANUAL mode: `sel` is a binary counter stepped by the step button. AUTO mode: `sel` is a timed one-hot chaser.

Parameters:
- DEB_CYCLES, 1_000_000, consecutive stable cycles needed to accept a button level change; must be >= 2.
- TICK_CYCLES, 25_000_000, clock cycles per AUTO chaser step; must be >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_step  input  1  raw step button, asynchronous, active-high.
- btn_mode  input  1  raw mode button, asynchronous, active-high.
- sel  output  3  LED select bus to the downstream LED driver; registered.
- auto_mode  output  1  1 = AUTO, 0 = MANUAL; registered.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset, sampled at a clk edge with rst=1:
  - sel=3'b000, auto_mode=0, FSM=MANUAL.
  - Sync flops, debounced levels and all counters cleared to 0.
  - Reset mid-debounce or mid-tick discards the partial count; a button still held high after reset is treated as a new press once it has been stable for DEB_CYCLES.
- Synchronizer: two flops per button. Raw input seen high at edge E reaches the sync output after edge E+1.
- Debouncer, per button:
  - Keeps the accepted level `db` and a counter `cnt` of width $clog2(DEB_CYCLES).
  - When sync==db: cnt<=0.
  - When sync!=db and cnt<DEB_CYCLES-1: cnt<=cnt+1.
  - When sync!=db and cnt==DEB_CYCLES-1: db<=sync, cnt<=0.
  - Any glitch shorter than DEB_CYCLES cycles is rejected.
- Press event: the clock edge on which db commits 0->1. That is edge E+1+DEB_CYCLES for a raw high first sampled at edge E and held. Release (1->0) produces no event. Holding the button produces exactly one event.
- FSM MANUAL:
  - Step event: sel<=sel+1, wrapping 3'b111 -> 3'b000.
  - Mode event: go to AUTO, sel<=3'b001, prescaler<=0, auto_mode<=1.
- FSM AUTO:
  - Prescaler counts 0..TICK_CYCLES-1 and wraps.
  - On the wrap edge, sel rotates left: 001 -> 010 -> 100 -> 001.
  - Step events are ignored.
  - Mode event: go to MANUAL, sel holds its current value, auto_mode<=0, prescaler<=0.
- Simultaneous step and mode events on the same edge: mode is processed, step is dropped.
- In AUTO, a mode event on the prescaler wrap edge: the mode transition wins and no rotation occurs.
- sel and auto_mode change only on clk edges and are glitch-free.

Optional Feature:
- Macro: LED_SEL_BOUNCE_EN.
- Defined: the AUTO chaser ping-pongs 001 -> 010 -> 100 -> 010 -> 001 -> ... using one direction flop.
  - Direction resets to "up" on reset and on every entry to AUTO.
  - Direction reverses on reaching 100 or 001.
- Undefined: plain left rotation as above; no direction flop is synthesized.

Test Plan (benches override DEB_CYCLES=4, TICK_CYCLES=8):
- Reset: hold rst=1 for 3 cycles with buttons toggling -> sel=000, auto_mode=0 throughout and on the first cycle after release.
- Debounce reject: btn_step high for 3 cycles then low -> sel stays 000. btn_step held 20 cycles -> sel=001 exactly 5 edges after first sampling, one step only.
- Manual wrap: 8 clean step presses from reset -> sel sequence 001, 010, ..., 111, 000.
- AUTO entry and chaser: sel=101, clean mode press -> sel=001 and auto_mode=1 on the commit edge; then 010 after 8 cycles, 100 after 16, 001 after 24; step presses during this have no effect.
- AUTO exit and simultaneity: mode press while sel=010 -> auto_mode=0, sel holds 010. Step and mode committed on the same edge in MANUAL -> AUTO entered with sel=001, no increment.
- LED_SEL_BOUNCE_EN defined: AUTO for 40 cycles -> sel sequence 001, 010, 100, 010, 001, 010.

Source files
------------

// File: rtl/led_sel_ctrl.sv
// led_sel_ctrl
//   Front-end control for the LED driver. Two raw push-buttons are
//   synchronised (2 flops each) and debounced (a level change is accepted
//   after DEB_CYCLES consecutive stable cycles). A two-state mode FSM then
//   drives the 3-bit select bus:
//     MANUAL : sel is a binary counter stepped by each step-button press.
//     AUTO   : sel is a one-hot chaser advanced every TICK_CYCLES clocks.
//   A mode-button press toggles between the two modes.
//
//   Optional build macro LED_SEL_BOUNCE_EN: when defined, the AUTO chaser
//   ping-pongs (001 -> 010 -> 100 -> 010 -> 001 ...) instead of rotating.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous reset, active-high
//   btn_step  in   raw step button (asynchronous, active-high)
//   btn_mode  in   raw mode button (asynchronous, active-high)
//   sel       out  [2:0] registered LED select bus
//   auto_mode out  registered mode flag, 1 = AUTO, 0 = MANUAL
module led_sel_ctrl #(
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int TICK_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_step,
    input  logic       btn_mode,
    output logic [2:0] sel,
    output logic       auto_mode
);

    localparam int            DW        = $clog2(DEB_CYCLES);
    localparam int            TW        = $clog2(TICK_CYCLES);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    // Button lanes: bit 0 = step, bit 1 = mode.
    localparam int B_STEP = 0;
    localparam int B_MODE = 1;

    typedef enum logic {
        S_MANUAL = 1'b0,
        S_AUTO   = 1'b1
    } state_t;

    logic [1:0]    meta_q, sync_q;
    logic [1:0]    db_q, db_d;
    logic [DW-1:0] cnt_q [2];
    logic [DW-1:0] cnt_d [2];
    logic [1:0]    press;

    state_t        state_q, state_d;
    logic [2:0]    sel_q, sel_d;
    logic [TW-1:0] presc_q, presc_d;
`ifdef LED_SEL_BOUNCE_EN
    logic          dir_up_q, dir_up_d;
`endif

    // Debouncers. The press pulse is combinational so the FSM acts on the
    // very edge where the debounced level commits 0->1.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = cnt_q[i];
            press[i] = 1'b0;
            if (sync_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DEB_LAST) begin
                db_d[i]  = sync_q[i];
                cnt_d[i] = '0;
                press[i] = sync_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + DW'(1);
            end
        end
    end

    // Mode FSM. A mode press always takes priority over a step press and
    // over a chaser tick landing on the same edge.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        presc_d  = presc_q;
`ifdef LED_SEL_BOUNCE_EN
        dir_up_d = dir_up_q;
`endif
        case (state_q)
            S_MANUAL: begin
                if (press[B_MODE]) begin
                    state_d  = S_AUTO;
                    sel_d    = 3'b001;
                    presc_d  = '0;
`ifdef LED_SEL_BOUNCE_EN
                    dir_up_d = 1'b1;
`endif
                end else if (press[B_STEP]) begin
                    sel_d = sel_q + 3'd1;
                end
            end
            S_AUTO: begin
                if (press[B_MODE]) begin
                    state_d = S_MANUAL;
                    presc_d = '0;
                end else if (presc_q == TICK_LAST) begin
                    presc_d = '0;
`ifdef LED_SEL_BOUNCE_EN
                    // Reverse at either end of the bar.
                    if (dir_up_q) begin
                        if (sel_q == 3'b100) begin
                            sel_d    = 3'b010;
                            dir_up_d = 1'b0;
                        end else begin
                            sel_d = {sel_q[1:0], 1'b0};
                        end
                    end else begin
                        if (sel_q == 3'b001) begin
                            sel_d    = 3'b010;
                            dir_up_d = 1'b1;
                        end else begin
                            sel_d = {1'b0, sel_q[2:1]};
                        end
                    end
`else
                    sel_d = {sel_q[1:0], sel_q[2]};
`endif
                end else begin
                    presc_d = presc_q + TW'(1);
                end
            end
            default: state_d = S_MANUAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q   <= '0;
            sync_q   <= '0;
            db_q     <= '0;
            for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
            state_q  <= S_MANUAL;
            sel_q    <= '0;
            presc_q  <= '0;
`ifdef LED_SEL_BOUNCE_EN
            dir_up_q <= 1'b1;
`endif
        end else begin
            meta_q   <= {btn_mode, btn_step};
            sync_q   <= meta_q;
            db_q     <= db_d;
            for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
            state_q  <= state_d;
            sel_q    <= sel_d;
            presc_q  <= presc_d;
`ifdef LED_SEL_BOUNCE_EN
            dir_up_q <= dir_up_d;
`endif
        end
    end

    assign sel       = sel_q;
    assign auto_mode = (state_q == S_AUTO);

endmodule

// File: tb/tb_led_sel_ctrl.sv
// Bench for led_sel_ctrl with DEB_CYCLES=4, TICK_CYCLES=8: a directed vector
// table, a few hand-written corner sequences and a randomized run against a
// behavioural model.
module tb_led_sel_ctrl;

    localparam int DEB  = 4;
    localparam int TICK = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_step = 1'b0;
    logic       btn_mode = 1'b0;
    logic [2:0] sel;
    logic       auto_mode;

    led_sel_ctrl #(.DEB_CYCLES(DEB), .TICK_CYCLES(TICK)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_step (btn_step),
        .btn_mode (btn_mode),
        .sel      (sel),
        .auto_mode(auto_mode)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Chaser pattern at position p since AUTO entry.
    function automatic logic [2:0] pat(input int p);
`ifdef LED_SEL_BOUNCE_EN
        case (p % 4)
            0:       return 3'b001;
            1:       return 3'b010;
            2:       return 3'b100;
            default: return 3'b010;
        endcase
`else
        return 3'(1 << (p % 3));
`endif
    endfunction

    // ---------------- behavioural model ----------------
    // raw_hist: raw {mode,step} sampled at each edge; the debouncer sees the
    // value from two edges earlier. seen_hist: what the debouncer saw since
    // the last reset. A level is accepted once the last DEB seen samples
    // (all after the previous acceptance) differ from the accepted level.
    logic [1:0] raw_hist  [$];
    logic [1:0] seen_hist [$];
    logic [1:0] acc;
    int         last_commit [2];
    bit         m_auto;
    logic [2:0] m_sel;
    int         m_ticks;
    int         m_pos;

    task automatic model_edge(input bit s, input bit m, input bit r);
        logic [1:0] seen;
        logic [1:0] ev;
        int         n;
        bit         ok;
        if (r) begin
            raw_hist.delete();
            raw_hist.push_back(2'b00);
            raw_hist.push_back(2'b00);
            seen_hist.delete();
            acc            = 2'b00;
            last_commit[0] = -1;
            last_commit[1] = -1;
            m_auto         = 1'b0;
            m_sel          = 3'b000;
            m_ticks        = 0;
            m_pos          = 0;
            return;
        end
        seen = raw_hist[raw_hist.size() - 2];
        raw_hist.push_back({m, s});
        void'(raw_hist.pop_front());
        seen_hist.push_back(seen);
        n  = seen_hist.size() - 1;
        ev = 2'b00;
        for (int b = 0; b < 2; b++) begin
            ok = (n - DEB + 1) > last_commit[b];
            if (ok)
                for (int k = 0; k < DEB; k++)
                    if (seen_hist[n - k][b] == acc[b]) ok = 1'b0;
            if (ok) begin
                acc[b]         = ~acc[b];
                last_commit[b] = n;
                ev[b]          = acc[b];
            end
        end
        if (!m_auto) begin
            if (ev[1]) begin
                m_auto  = 1'b1;
                m_ticks = 0;
                m_pos   = 0;
                m_sel   = pat(0);
            end else if (ev[0]) begin
                m_sel = 3'((int'(m_sel) + 1) % 8);
            end
        end else begin
            if (ev[1]) begin
                m_auto = 1'b0;
            end else begin
                m_ticks++;
                if (m_ticks % TICK == 0) begin
                    m_pos++;
                    m_sel = pat(m_pos);
                end
            end
        end
    endtask

    // Drive inputs, take one clock edge, advance the model, sample 1 ns later.
    task automatic cyc(input bit s, input bit m, input bit r);
        btn_step = s;
        btn_mode = m;
        rst      = r;
        @(posedge clk);
        model_edge(s, m, r);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] exp_sel, input bit exp_auto);
        n_chk++;
        if (sel === exp_sel && auto_mode === exp_auto) begin
            n_pass++;
        end else begin
            $display("FAIL %s: sel=%b auto_mode=%b, expected sel=%b auto_mode=%b",
                     name, sel, auto_mode, exp_sel, exp_auto);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string      name;
        bit         r;
        bit         s;
        bit         m;
        int         n;
        logic [2:0] sel;
        bit         am;
    } vec_t;

    vec_t tbl [$];

    function automatic void add(input string name, input bit r, input bit s, input bit m,
                                input int n, input logic [2:0] es, input bit ea);
        vec_t v;
        v.name = name; v.r = r; v.s = s; v.m = m; v.n = n; v.sel = es; v.am = ea;
        tbl.push_back(v);
    endfunction

    initial begin
        raw_hist.push_back(2'b00);
        raw_hist.push_back(2'b00);
        acc = 2'b00; last_commit[0] = -1; last_commit[1] = -1;
        m_auto = 1'b0; m_sel = 3'b000; m_ticks = 0; m_pos = 0;

        // Reset with buttons toggling, then glitch reject and a long hold.
        add("rst_both",   1, 1, 1, 1, 3'd0, 0);
        add("rst_mode",   1, 0, 1, 1, 3'd0, 0);
        add("rst_step",   1, 1, 0, 1, 3'd0, 0);
        add("post_rst",   0, 0, 0, 1, 3'd0, 0);
        add("idle",       0, 0, 0, 8, 3'd0, 0);
        add("glitch_hi",  0, 1, 0, 3, 3'd0, 0);
        add("glitch_lo",  0, 0, 0, 8, 3'd0, 0);
        add("hold_pre",   0, 1, 0, 5, 3'd0, 0);
        add("hold_commit",0, 1, 0, 1, 3'd1, 0);
        add("hold_long",  0, 1, 0, 14, 3'd1, 0);
        add("hold_rel",   0, 0, 0, 6, 3'd1, 0);
        // Seven more presses: 010 .. 111, 000.
        for (int v = 2; v <= 8; v++) begin
            add("wrap_press", 0, 1, 0, 6, 3'(v % 8), 0);
            add("wrap_rel",   0, 0, 0, 6, 3'(v % 8), 0);
        end
        for (int v = 1; v <= 5; v++) begin
            add("to5_press", 0, 1, 0, 6, 3'(v), 0);
            add("to5_rel",   0, 0, 0, 6, 3'(v), 0);
        end
        // AUTO entry at commit edge C, chaser, ignored step press, exit.
        add("mode_pre",   0, 0, 1, 5, 3'd5, 0);
        add("mode_commit",0, 0, 1, 1, pat(0), 1);
        add("auto_hold",  0, 0, 0, 7, pat(0), 1);
        add("auto_t8",    0, 0, 0, 1, pat(1), 1);
        add("auto_step",  0, 1, 0, 6, pat(1), 1);
        add("auto_t16",   0, 0, 0, 2, pat(2), 1);
        add("auto_rel",   0, 0, 0, 4, pat(2), 1);
        add("auto_t24",   0, 0, 0, 4, pat(3), 1);
        add("exit_gap",   0, 0, 0, 4, pat(3), 1);
        add("exit_pre",   0, 0, 1, 5, pat(4), 1);
        add("exit_commit",0, 0, 1, 1, pat(4), 0);
        add("manual_hold",0, 0, 0, 12, pat(4), 0);
        // Step and mode committing on the same edge.
        add("both_pre",   0, 1, 1, 5, pat(4), 0);
        add("both_commit",0, 1, 1, 1, 3'b001, 1);
        add("both_rel",   0, 0, 0, 6, 3'b001, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            for (int c = 0; c < tbl[i].n; c++) cyc(tbl[i].s, tbl[i].m, tbl[i].r);
            check(tbl[i].name, tbl[i].sel, tbl[i].am);
        end

        // Mode press landing on the chaser wrap edge: no rotation.
        cyc(0, 0, 1);
        for (int c = 0; c < 6; c++) cyc(0, 1, 0);
        check("wrapedge_entry", 3'b001, 1);
        for (int c = 0; c < 10; c++) cyc(0, 0, 0);
        check("wrapedge_t8", pat(1), 1);
        for (int c = 0; c < 5; c++) cyc(0, 1, 0);
        check("wrapedge_pre", pat(1), 1);
        cyc(0, 1, 0);
        check("wrapedge_commit", pat(1), 0);
        for (int c = 0; c < 12; c++) cyc(0, 0, 0);
        check("wrapedge_after", pat(1), 0);

        // Reset in the middle of a debounce with the button still held.
        cyc(0, 0, 1);
        for (int c = 0; c < 3; c++) cyc(1, 0, 0);
        cyc(1, 0, 1);
        for (int c = 0; c < 5; c++) cyc(1, 0, 0);
        check("midrst_pre", 3'b000, 0);
        cyc(1, 0, 0);
        check("midrst_commit", 3'b001, 0);
        for (int c = 0; c < 8; c++) cyc(0, 0, 0);
        check("midrst_after", 3'b001, 0);

        // Forty cycles of chaser from entry.
        cyc(0, 0, 1);
        for (int c = 0; c < 6; c++) cyc(0, 1, 0);
        check("chase_0", pat(0), 1);
        for (int k = 1; k <= 5; k++) begin
            for (int c = 0; c < TICK; c++) cyc(0, 0, 0);
            check("chase_k", pat(k), 1);
        end

        // Randomized run against the model.
        cyc(0, 0, 1);
        for (int seg = 0; seg < 250; seg++) begin
            bit s;
            bit m;
            bit r;
            int len;
            r   = ($urandom_range(0, 39) == 0);
            s   = ($urandom_range(0, 2) == 0);
            m   = ($urandom_range(0, 3) == 0);
            len = r ? 1 : int'($urandom_range(1, 12));
            for (int i = 0; i < len; i++) begin
                cyc(s, m, r);
                check("rand", m_sel, m_auto);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
